// File: rtl/iter_mul_unit.sv
// rtl/iter_mul_unit.sv - iterative shift-add multiplier (MUL/MULH/MULHSU/MULHU) with CDB result hold
// Define ITER_MUL_RADIX4_EN to retire two multiplier bits per CALC cycle instead of one.
module iter_mul_unit #(
   parameter int XLEN      = 32,
   parameter int ROB_IDX_W = 5
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 issue_valid,
   output logic                 issue_ready,
   input  logic [1:0]           issue_op,
   input  logic [XLEN-1:0]      issue_rs1,
   input  logic [XLEN-1:0]      issue_rs2,
   input  logic [ROB_IDX_W-1:0] issue_rob_idx,
   input  logic                 flush,
   output logic                 status_w_en,
   output logic                 status_start,
   output logic                 status_done,
   output logic                 busy_o,
   output logic                 cdb_valid,
   input  logic                 cdb_ready,
   output logic [ROB_IDX_W-1:0] cdb_rob_idx,
   output logic [XLEN-1:0]      cdb_data
);

   localparam int PROD_W = 2 * XLEN;
`ifdef ITER_MUL_RADIX4_EN
   localparam int BITS_PER_CYC = 2;
`else
   localparam int BITS_PER_CYC = 1;
`endif
   localparam int LAST_CNT = XLEN / BITS_PER_CYC - 1;
   localparam int CNT_W    = $clog2(XLEN);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_WAIT_CDB} state_t;

   state_t              state;
   logic [CNT_W-1:0]    cnt;
   logic [PROD_W-1:0]   acc;
   logic [PROD_W-1:0]   mcand_sh;
   logic [XLEN-1:0]     mplier;
   logic                neg_q;
   logic [1:0]          op_q;
   logic                cdb_valid_q;

   logic                fire;
   logic                kill;
   logic                handshake;
   logic                rs1_signed;
   logic                rs2_signed;
   logic                rs1_neg;
   logic                rs2_neg;
   logic [XLEN-1:0]     rs1_mag;
   logic [XLEN-1:0]     rs2_mag;
   logic [PROD_W-1:0]   pp;
   logic [PROD_W-1:0]   acc_next;
   logic [PROD_W-1:0]   prod_final;

   assign issue_ready  = (state == S_IDLE) && !flush;
   assign fire         = issue_valid && issue_ready;
   assign kill         = flush && (state != S_IDLE);
   assign cdb_valid    = cdb_valid_q && !flush;
   assign handshake    = cdb_valid && cdb_ready;
   assign status_start = rst_n && fire;
   assign status_done  = rst_n && (handshake || kill);
   assign status_w_en  = status_start || status_done;
   assign busy_o       = (state != S_IDLE);

   // MUL takes the low half, where operand signedness does not matter; treat it as s*s.
   always_comb begin
      rs1_signed = (issue_op != 2'd3);
      rs2_signed = (issue_op == 2'd0) || (issue_op == 2'd1);
      rs1_neg    = rs1_signed && issue_rs1[XLEN-1];
      rs2_neg    = rs2_signed && issue_rs2[XLEN-1];
      rs1_mag    = rs1_neg ? ((~issue_rs1) + XLEN'(1)) : issue_rs1;
      rs2_mag    = rs2_neg ? ((~issue_rs2) + XLEN'(1)) : issue_rs2;
   end

   always_comb begin
      pp = '0;
`ifdef ITER_MUL_RADIX4_EN
      pp = (mplier[0] ? mcand_sh : '0) + (mplier[1] ? {mcand_sh[PROD_W-2:0], 1'b0} : '0);
`else
      pp = mplier[0] ? mcand_sh : '0;
`endif
      acc_next   = acc + pp;
      prod_final = neg_q ? ((~acc_next) + PROD_W'(1)) : acc_next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         cnt         <= '0;
         acc         <= '0;
         mcand_sh    <= '0;
         mplier      <= '0;
         neg_q       <= 1'b0;
         op_q        <= 2'd0;
         cdb_valid_q <= 1'b0;
         cdb_data    <= '0;
         cdb_rob_idx <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (fire) begin
                  mcand_sh    <= {{XLEN{1'b0}}, rs1_mag};
                  mplier      <= rs2_mag;
                  neg_q       <= rs1_neg ^ rs2_neg;
                  op_q        <= issue_op;
                  cdb_rob_idx <= issue_rob_idx;
                  acc         <= '0;
                  cnt         <= '0;
                  state       <= S_CALC;
               end
            end
            S_CALC: begin
               if (flush) begin
                  state <= S_IDLE;
               end else begin
                  acc      <= acc_next;
                  mplier   <= mplier >> BITS_PER_CYC;
                  mcand_sh <= mcand_sh << BITS_PER_CYC;
                  // Last partial product is folded in and the sign applied on the way out.
                  if (cnt == CNT_W'(LAST_CNT)) begin
                     cdb_data    <= (op_q == 2'd0) ? prod_final[XLEN-1:0]
                                                   : prod_final[PROD_W-1:XLEN];
                     cdb_valid_q <= 1'b1;
                     state       <= S_WAIT_CDB;
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            S_WAIT_CDB: begin
               if (flush || handshake) begin
                  cdb_valid_q <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: begin
               cdb_valid_q <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_iter_mul_unit.sv
// tb/tb_iter_mul_unit.sv - directed self-checking bench for iter_mul_unit
// Build with ITER_MUL_RADIX4_EN defined to exercise the two-bit-per-cycle variant.
module tb_iter_mul_unit;

   localparam int XLEN = 32;
   localparam int RW   = 5;
`ifdef ITER_MUL_RADIX4_EN
   localparam int LAT = XLEN / 2 + 1;
`else
   localparam int LAT = XLEN + 1;
`endif

   logic            clk;
   logic            rst_n;
   logic            issue_valid;
   logic            issue_ready;
   logic [1:0]      issue_op;
   logic [XLEN-1:0] issue_rs1;
   logic [XLEN-1:0] issue_rs2;
   logic [RW-1:0]   issue_rob_idx;
   logic            flush;
   logic            status_w_en;
   logic            status_start;
   logic            status_done;
   logic            busy_o;
   logic            cdb_valid;
   logic            cdb_ready;
   logic [RW-1:0]   cdb_rob_idx;
   logic [XLEN-1:0] cdb_data;

   int n_checks = 0;
   int n_fail   = 0;
   int n_start  = 0;
   int n_done   = 0;

   iter_mul_unit #(.XLEN(XLEN), .ROB_IDX_W(RW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .issue_valid   (issue_valid),
      .issue_ready   (issue_ready),
      .issue_op      (issue_op),
      .issue_rs1     (issue_rs1),
      .issue_rs2     (issue_rs2),
      .issue_rob_idx (issue_rob_idx),
      .flush         (flush),
      .status_w_en   (status_w_en),
      .status_start  (status_start),
      .status_done   (status_done),
      .busy_o        (busy_o),
      .cdb_valid     (cdb_valid),
      .cdb_ready     (cdb_ready),
      .cdb_rob_idx   (cdb_rob_idx),
      .cdb_data      (cdb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (status_start) n_start++;
      if (status_done)  n_done++;
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Issue one op with cdb_ready high; check latency, data, tag and pulses.
   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
      int          lat;
      logic [31:0] obs_data;
      logic [4:0]  obs_rob;
      logic        obs_done;
      lat = -1; obs_data = '0; obs_rob = '0; obs_done = 1'b0;
      @(posedge clk); #1;
      issue_op = op; issue_rs1 = a; issue_rs2 = b; issue_rob_idx = tag;
      issue_valid = 1'b1; cdb_ready = 1'b1;
      @(negedge clk);
      check_eq({name, " start"}, 64'(status_start), 64'd1);
      check_eq({name, " w_en@start"}, 64'(status_w_en), 64'd1);
      @(posedge clk); #1;
      issue_valid = 1'b0;
      for (int k = 1; k <= LAT + 5; k++) begin
         @(negedge clk);
         if (cdb_valid) begin
            lat = k; obs_data = cdb_data; obs_rob = cdb_rob_idx; obs_done = status_done;
            break;
         end
         @(posedge clk); #1;
      end
      check_eq({name, " latency"}, 64'(lat), 64'(LAT));
      check_eq({name, " data"}, 64'(obs_data), 64'(exp));
      check_eq({name, " rob"}, 64'(obs_rob), 64'(tag));
      check_eq({name, " done"}, 64'(obs_done), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq({name, " idle busy"}, 64'(busy_o), 64'd0);
   endtask

   initial begin
      int s0, d0;
      logic stable;
      logic seen;
      rst_n = 1'b0; issue_valid = 1'b0; issue_op = 2'd0; issue_rs1 = '0; issue_rs2 = '0;
      issue_rob_idx = '0; flush = 1'b0; cdb_ready = 1'b0;
      #12;
      check_eq("rst cdb_valid", 64'(cdb_valid), 64'd0);
      check_eq("rst busy", 64'(busy_o), 64'd0);
      check_eq("rst issue_ready", 64'(issue_ready), 64'd1);
      check_eq("rst w_en", 64'(status_w_en), 64'd0);
      check_eq("rst cdb_data", 64'(cdb_data), 64'd0);
      check_eq("rst cdb_rob", 64'(cdb_rob_idx), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      do_op("mulhu_ff",   2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'hFFFFFFFE);
      do_op("mul_m3x5",   2'd0, 32'hFFFFFFFD, 32'h00000005, 5'd3,  32'hFFFFFFF1);
      do_op("mulhsu_ff",  2'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd12, 32'hFFFFFFFF);
      do_op("mulh_min",   2'd1, 32'h80000000, 32'h80000000, 5'd31, 32'h40000000);
      do_op("mul_zero",   2'd0, 32'h00000000, 32'h12345678, 5'd1,  32'h00000000);
      do_op("mulh_m1m1",  2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2,  32'h00000000);
      do_op("mul_minm1",  2'd0, 32'h80000000, 32'hFFFFFFFF, 5'd4,  32'h80000000);
      do_op("mulhsu_min", 2'd2, 32'h80000000, 32'hFFFFFFFF, 5'd5,  32'h80000000);
      do_op("mul_x9",     2'd0, 32'h12345678, 32'h00000009, 5'd6,  32'hA3D70A38);
      do_op("mulhu_sh",   2'd3, 32'h80000000, 32'h00000004, 5'd8,  32'h00000002);

      // Back-pressure: hold result for 10 cycles with cdb_ready low.
      @(posedge clk); #1;
      issue_op = 2'd0; issue_rs1 = 32'd7; issue_rs2 = 32'd6; issue_rob_idx = 5'd9;
      issue_valid = 1'b1; cdb_ready = 1'b0;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < LAT + 5 && !seen; k++) begin
         @(negedge clk);
         seen = cdb_valid;
         if (!seen) begin @(posedge clk); #1; end
      end
      check_eq("stall valid seen", 64'(seen), 64'd1);
      stable = 1'b1;
      for (int k = 0; k < 10; k++) begin
         if (k > 0) @(negedge clk);
         if (!(cdb_valid && cdb_data == 32'd42 && !issue_ready && busy_o && !status_done))
            stable = 1'b0;
         @(posedge clk); #1;
      end
      check_eq("stall hold", 64'(stable), 64'd1);
      cdb_ready = 1'b1;
      @(negedge clk);
      check_eq("stall done", 64'(status_done), 64'd1);
      check_eq("stall data", 64'(cdb_data), 64'd42);
      @(posedge clk); #1;
      @(negedge clk);
      check_eq("stall idle", 64'(busy_o), 64'd0);

      // Flush at CALC cycle 5.
      @(posedge clk); #1;
      issue_op = 2'd0; issue_rs1 = 32'd3; issue_rs2 = 32'd3; issue_rob_idx = 5'd1;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      repeat (4) begin @(posedge clk); #1; end
      flush = 1'b1;
      @(negedge clk);
      check_eq("flush done", 64'(status_done), 64'd1);
      check_eq("flush w_en", 64'(status_w_en), 64'd1);
      check_eq("flush valid", 64'(cdb_valid), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check_eq("flush ready next", 64'(issue_ready), 64'd1);
      seen = 1'b0;
      for (int k = 0; k < LAT + 2; k++) begin
         @(negedge clk);
         if (cdb_valid) seen = 1'b1;
      end
      check_eq("flush no valid", 64'(seen), 64'd0);
      do_op("post_flush", 2'd1, 32'hFFFFFFFE, 32'h00000003, 5'd10, 32'hFFFFFFFF);

      // Flush while idle: nothing accepted, no pulse.
      @(posedge clk); #1;
      flush = 1'b1; issue_valid = 1'b1;
      @(negedge clk);
      check_eq("iflush ready", 64'(issue_ready), 64'd0);
      check_eq("iflush w_en", 64'(status_w_en), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; issue_valid = 1'b0;
      @(negedge clk);
      check_eq("iflush busy", 64'(busy_o), 64'd0);

      // Reset mid-CALC.
      @(posedge clk); #1;
      issue_op = 2'd3; issue_rs1 = 32'hFFFFFFFF; issue_rs2 = 32'h2; issue_rob_idx = 5'd17;
      issue_valid = 1'b1;
      @(posedge clk); #1;
      issue_valid = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      d0 = n_done;
      rst_n = 1'b0;
      #1;
      check_eq("mrst busy", 64'(busy_o), 64'd0);
      check_eq("mrst valid", 64'(cdb_valid), 64'd0);
      check_eq("mrst w_en", 64'(status_w_en), 64'd0);
      check_eq("mrst data", 64'(cdb_data), 64'd0);
      check_eq("mrst rob", 64'(cdb_rob_idx), 64'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_eq("mrst no done", 64'(n_done - d0), 64'd0);
      s0 = n_start; d0 = n_done;
      do_op("b2b_a", 2'd0, 32'h0000FFFF, 32'h0000FFFF, 5'd11, 32'hFFFE0001);
      do_op("b2b_b", 2'd3, 32'h0000FFFF, 32'h00010001, 5'd13, 32'h00000000);
      check_eq("b2b starts", 64'(n_start - s0), 64'd2);
      check_eq("b2b dones", 64'(n_done - d0), 64'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/iter_mul_unit.md
ITER_MUL_UNIT -- requirements
Module: iter_mul_unit

Interface
REQ-001 Parameter XLEN, default 32, operand/result width; even, >= 4.
REQ-002 Parameter ROB_IDX_W, default 5, width of the ROB tag carried with each operation.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 issue_valid  input  1  reservation station presents an operation.
REQ-006 issue_ready  output  1  unit accepts this cycle; issue fires when issue_valid && issue_ready.
REQ-007 issue_op  input  2  0=MUL (low half), 1=MULH (s*s high), 2=MULHSU (s*u high), 3=MULHU (u*u high).
REQ-008 issue_rs1, issue_rs2  input  XLEN each  operands.
REQ-009 issue_rob_idx  input  ROB_IDX_W  tag.
REQ-010 flush  input  1  kill any in-flight operation.
REQ-011 status_w_en, status_start, status_done  output  1 each  status pulses toward the per-unit busy tracker.
REQ-012 busy_o  output  1  high in every state except IDLE.
REQ-013 cdb_valid  output  1  result held for the common data bus.
REQ-014 cdb_ready  input  1  CDB grant; result retires when cdb_valid && cdb_ready.
REQ-015 cdb_rob_idx  output  ROB_IDX_W; cdb_data  output  XLEN  result tag and value.

Function
REQ-016 FSM states IDLE, CALC, WAIT_CDB; IDLE->CALC on issue fire, CALC->WAIT_CDB when iteration count reaches its final value, WAIT_CDB->IDLE on CDB handshake.
REQ-017 issue_ready = (state==IDLE) && !flush, combinational.
REQ-018 On issue fire, operands, op and tag are latched; signed operands (per op) are converted to magnitudes and the result sign recorded.
REQ-019 CALC performs unsigned shift-add on magnitudes into a 2*XLEN accumulator, 1 multiplier bit per cycle: XLEN CALC cycles.
REQ-020 Issue fire at cycle T -> cdb_valid first high in cycle T+XLEN+1 (radix-2).
REQ-021 Final 2*XLEN product is two's-complement negated when recorded sign is negative, before entering WAIT_CDB.
REQ-022 cdb_data = product[XLEN-1:0] for MUL, product[2*XLEN-1:XLEN] otherwise; registered, stable while cdb_valid && !cdb_ready.
REQ-023 status_start and status_w_en asserted combinationally in the issue-fire cycle; busy_o high from the next cycle.
REQ-024 status_done and status_w_en asserted combinationally in the CDB-handshake cycle; busy_o low from the next cycle.
REQ-025 status_start and status_done never asserted in the same cycle.
REQ-026 cdb_valid held high until accepted; unit accepts no new issue while in WAIT_CDB.
REQ-027 flush in CALC or WAIT_CDB: cdb_valid forced low that cycle, status_done and status_w_en pulsed, state -> IDLE next cycle; no CDB handshake counted.
REQ-028 flush in IDLE: no issue accepted, no status pulse, state unchanged.
REQ-029 Operand 0 or most-negative value handled exactly (e.g., MULH 0x80000000*0x80000000 = 0x40000000).

Reset
REQ-030 rst_n low: state=IDLE, counter=0, accumulator=0, cdb_valid=0, busy_o=0, all status pulses 0, cdb_data=0, cdb_rob_idx=0, effective immediately without a clock edge.
REQ-031 Reset asserted mid-CALC or WAIT_CDB discards the operation with no status_done pulse.

Configuration
REQ-032 Macro ITER_MUL_RADIX4_EN defined: CALC retires 2 multiplier bits per cycle, XLEN/2 CALC cycles, cdb_valid first high at T+XLEN/2+1; undefined: radix-2 behaviour per REQ-019/020; results identical in both builds.

Verification
REQ-033 MULHU 0xFFFFFFFF*0xFFFFFFFF, tag 7, cdb_ready=1 -> cdb_valid at T+33, cdb_data 0xFFFFFFFE, cdb_rob_idx 7, done pulse that cycle.
REQ-034 MUL 0xFFFFFFFD*0x00000005 (-3*5) -> cdb_data 0xFFFFFFF1; MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
REQ-035 cdb_ready low 10 cycles after result -> cdb_valid and cdb_data stable, issue_ready low, busy_o high throughout.
REQ-036 flush at CALC cycle 5 -> cdb_valid never rises, status_done pulse same cycle, issue_ready high next cycle, next op result correct.
REQ-037 rst_n low mid-CALC -> all outputs at reset values immediately; back-to-back issues after release each complete with one start and one done pulse.
REQ-038 With ITER_MUL_RADIX4_EN, REQ-033 stimulus -> same data at T+17.
